// File: rtl/l2_req_fifo_pkg.sv
// l2q_pkg: shared op/state encodings and the queue entry record for the L2 request queue
//   OP_RD/OP_WR/OP_PWB request ops (OP_ILL is never stored)
//   ST_IDLE/ST_FILL     fill FSM states
//   entry_t             per-slot control record {valid, complete, op, addr}
package l2q_pkg;
    localparam int L2Q_ADDR_W = 32;
    typedef enum logic [1:0] {
        OP_RD  = 2'b00,
        OP_WR  = 2'b01,
        OP_PWB = 2'b10,
        OP_ILL = 2'b11
    } op_e;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;
    typedef struct packed {
        logic                  valid;
        logic                  complete;
        op_e                   op;
        logic [L2Q_ADDR_W-1:0] addr;
    } entry_t;
endpackage

// File: rtl/l2_req_fifo_if.sv
// l2_req_fifo_if: push/beat/pop/search/fetch bundle of the L2 request queue
//   master: request producer + consumer side (drives push_*, beat_*, pop_ready, search_*, fetch_*)
//   slave : the queue itself (drives push_ready, pop_*, search results, fetch results, count/empty/full)
interface l2_req_fifo_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEATS      = 4,
    parameter int DEPTH_BIT  = 4
);
    logic                        push_valid;
    logic                        push_ready;
    logic [1:0]                  push_op;
    logic [ADDR_WIDTH-1:0]       push_addr;
    logic                        beat_valid;
    logic [DATA_WIDTH-1:0]       beat_data;
    logic                        pop_valid;
    logic                        pop_ready;
    logic [1:0]                  pop_op;
    logic [ADDR_WIDTH-1:0]       pop_addr;
    logic [BEATS*DATA_WIDTH-1:0] pop_data;
    logic                        search_en;
    logic [ADDR_WIDTH-1:0]       search_addr;
    logic                        search_hit;
    logic [DEPTH_BIT-1:0]        search_idx;
    logic                        search_pending;
    logic                        fetch_en;
    logic [DEPTH_BIT-1:0]        fetch_idx;
    logic                        fetch_valid;
    logic [BEATS*DATA_WIDTH-1:0] fetch_data;
    logic [DEPTH_BIT:0]          count;
    logic                        empty;
    logic                        full;
    modport master (
        output push_valid, push_op, push_addr, beat_valid, beat_data, pop_ready,
               search_en, search_addr, fetch_en, fetch_idx,
        input  push_ready, pop_valid, pop_op, pop_addr, pop_data, search_hit, search_idx,
               search_pending, fetch_valid, fetch_data, count, empty, full
    );
    modport slave (
        input  push_valid, push_op, push_addr, beat_valid, beat_data, pop_ready,
               search_en, search_addr, fetch_en, fetch_idx,
        output push_ready, pop_valid, pop_op, pop_addr, pop_data, search_hit, search_idx,
               search_pending, fetch_valid, fetch_data, count, empty, full
    );
endinterface

// File: rtl/l2_req_fifo_match.sv
// l2q_match: combinational youngest-match finder over the queue's valid PWB entries
//   valid_i/op_i/line_i  per-slot valid bit, op and line address
//   rd_ptr_i             oldest slot; scan runs from here towards the newest
//   key_i                line address to find
//   hit_o/idx_o          match found / slot of the youngest match (0 when no hit)
module l2q_match
    import l2q_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int DEPTH_BIT = 4,
    parameter int LINE_W    = 28
) (
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [DEPTH-1:0][1:0]        op_i,
    input  logic [DEPTH-1:0][LINE_W-1:0] line_i,
    input  logic [DEPTH_BIT-1:0]         rd_ptr_i,
    input  logic [LINE_W-1:0]            key_i,
    output logic                         hit_o,
    output logic [DEPTH_BIT-1:0]         idx_o
);
    logic [DEPTH_BIT-1:0] j;
    // Later matches overwrite earlier ones, so the youngest entry wins.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        j     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            j = DEPTH_BIT'(rd_ptr_i + DEPTH_BIT'(k));
            if (valid_i[j] && op_i[j] == OP_PWB && line_i[j] == key_i) begin
                hit_o = 1'b1;
                idx_o = j;
            end
        end
    end
endmodule

// File: rtl/l2_req_fifo.sv
// l2_req_fifo: in-order L2 request queue of RD/WR/PWB requests with multi-beat write lines
//   clk, rst      clock, synchronous active-high reset
//   bus (slave)   push/beat entry, head pop, youngest-PWB search, indexed line fetch,
//                 count/empty/full occupancy
//   stat_push, stat_stall  saturating push/stall counters, present only with L2Q_STATS_EN defined
module l2_req_fifo
    import l2q_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEATS      = 4,
    parameter int DEPTH      = 16,
    parameter int DEPTH_BIT  = 4,
    parameter int LINE_OFF   = 4
) (
    input  logic        clk,
    input  logic        rst,
    l2_req_fifo_if.slave bus
`ifdef L2Q_STATS_EN
    ,
    output logic [15:0] stat_push,
    output logic [15:0] stat_stall
`endif
);
    localparam int LINE_W = ADDR_WIDTH - LINE_OFF;
    localparam int LW     = BEATS * DATA_WIDTH;
    localparam int BCW    = BEATS > 1 ? $clog2(BEATS) : 1;

    entry_t                      ent_q [DEPTH];
    logic [LW-1:0]               line_q [DEPTH];
    state_e                      state_q, state_d;
    logic [DEPTH_BIT-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, fill_idx_q;
    logic [DEPTH_BIT:0]          count_q, count_d;
    logic [BCW-1:0]              beat_cnt_q, beat_cnt_d;
    logic                        srch_hit_q, srch_pend_q, fetch_valid_q;
    logic [DEPTH_BIT-1:0]        srch_idx_q;
    logic [LW-1:0]               fetch_data_q;
    logic                        push_ready, pop_valid, push_fire, pop_fire, beat_fire, fill_done;
    logic                        fetch_ok, m_hit;
    logic [DEPTH_BIT-1:0]        m_idx;
    logic [DEPTH-1:0]            v_vec;
    logic [DEPTH-1:0][1:0]       op_vec;
    logic [DEPTH-1:0][LINE_W-1:0] line_vec;

    assign bus.full           = count_q == (DEPTH_BIT+1)'(DEPTH);
    assign bus.empty          = count_q == '0;
    assign bus.count          = count_q;
    assign bus.push_ready     = push_ready;
    assign bus.pop_valid      = pop_valid;
    assign bus.pop_op         = ent_q[rd_ptr_q].op;
    assign bus.pop_addr       = ADDR_WIDTH'(ent_q[rd_ptr_q].addr);
    assign bus.pop_data       = line_q[rd_ptr_q];
    assign bus.search_hit     = srch_hit_q;
    assign bus.search_idx     = srch_idx_q;
    assign bus.search_pending = srch_pend_q;
    assign bus.fetch_valid    = fetch_valid_q;
    assign bus.fetch_data     = fetch_data_q;

    // Next-state and handshake decode; an op of 11 is handshaken but never allocated.
    always_comb begin
        push_ready = !bus.full && state_q == ST_IDLE;
        pop_valid  = ent_q[rd_ptr_q].valid && ent_q[rd_ptr_q].complete;
        push_fire  = bus.push_valid && push_ready && bus.push_op != OP_ILL;
        pop_fire   = pop_valid && bus.pop_ready;
        beat_fire  = state_q == ST_FILL && bus.beat_valid;
        fill_done  = beat_fire && beat_cnt_q == BCW'(BEATS - 1);
        state_d    = fill_done ? ST_IDLE : (push_fire && bus.push_op != OP_RD) ? ST_FILL : state_q;
        beat_cnt_d = push_fire ? '0 : beat_fire ? beat_cnt_q + 1'b1 : beat_cnt_q;
        wr_ptr_d   = push_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = push_fire == pop_fire ? count_q : push_fire ? count_q + 1'b1 : count_q - 1'b1;
        fetch_ok   = ent_q[bus.fetch_idx].valid && ent_q[bus.fetch_idx].complete &&
                     ent_q[bus.fetch_idx].op != OP_RD;
    end

    always_comb begin
        v_vec    = '0;
        op_vec   = '0;
        line_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_vec[i]    = ent_q[i].valid;
            op_vec[i]   = ent_q[i].op;
            line_vec[i] = ent_q[i].addr[ADDR_WIDTH-1:LINE_OFF];
        end
    end

    l2q_match #(.DEPTH(DEPTH), .DEPTH_BIT(DEPTH_BIT), .LINE_W(LINE_W)) u_match (
        .valid_i  (v_vec),
        .op_i     (op_vec),
        .line_i   (line_vec),
        .rd_ptr_i (rd_ptr_q),
        .key_i    (bus.search_addr[ADDR_WIDTH-1:LINE_OFF]),
        .hit_o    (m_hit),
        .idx_o    (m_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else state_q <= state_d;
    end

    // Search and fetch sample the storage as it stands before this edge's push/pop/beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            fill_idx_q    <= '0;
            count_q       <= '0;
            beat_cnt_q    <= '0;
            srch_hit_q    <= 1'b0;
            srch_idx_q    <= '0;
            srch_pend_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            beat_cnt_q <= beat_cnt_d;
            if (push_fire) begin
                ent_q[wr_ptr_q] <= '{valid: 1'b1, complete: bus.push_op == OP_RD,
                                     op: op_e'(bus.push_op), addr: L2Q_ADDR_W'(bus.push_addr)};
                fill_idx_q      <= wr_ptr_q;
            end
            if (beat_fire) line_q[fill_idx_q][beat_cnt_q*DATA_WIDTH +: DATA_WIDTH] <= bus.beat_data;
            if (fill_done) ent_q[fill_idx_q].complete <= 1'b1;
            if (pop_fire) ent_q[rd_ptr_q].valid <= 1'b0;
            if (bus.search_en) begin
                srch_hit_q  <= m_hit;
                srch_idx_q  <= m_idx;
                srch_pend_q <= m_hit && !ent_q[m_idx].complete;
            end
            if (bus.fetch_en) begin
                fetch_valid_q <= fetch_ok;
                fetch_data_q  <= fetch_ok ? line_q[bus.fetch_idx] : '0;
            end
        end
    end

`ifdef L2Q_STATS_EN
    logic [15:0] stat_push_q, stat_stall_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_push_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            if (bus.push_valid && push_ready && stat_push_q != 16'hFFFF) stat_push_q <= stat_push_q + 1'b1;
            if (bus.push_valid && !push_ready && stat_stall_q != 16'hFFFF) stat_stall_q <= stat_stall_q + 1'b1;
        end
    end
    assign stat_push  = stat_push_q;
    assign stat_stall = stat_stall_q;
`endif
endmodule
